led_scanner: RTL and testbench
==============================

LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 Parameter WIDTH, default 10: number of LED outputs; SHALL be >= 2.
REQ-002 Parameter DIV, default 500000: clk cycles per step; SHALL be >= 1.
REQ-003 Derived constant PW = $clog2(WIDTH+1): width of pos.
REQ-004 clk  input  1  rising-edge clock; the only clock in the block.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 en  input  1  high = divider runs and pattern advances; low = everything holds.
REQ-007 mode  input  2  pattern select: 00 BOUNCE, 01 WRAP, 10 FILL, 11 reserved.
REQ-008 out  output  WIDTH  registered LED drive.
REQ-009 pos  output  PW  current position/level, registered.
REQ-010 dir  output  1  registered direction: 1 = up (toward MSB), 0 = down.
REQ-011 tick  output  1  registered one-cycle strobe marking each step.

Function
REQ-012 No derived or gated clocks; all state SHALL use clk; the divider produces a clock-enable only.
REQ-013 Divider: counts 0..DIV-1 while en=1. At DIV-1 it asserts tick for exactly one cycle and returns to 0. DIV=1 gives a tick on every enabled cycle.
REQ-014 en=0: divider, pos, dir, out and mode_q hold; tick=0.
REQ-015 A step (pos/dir/out update) SHALL occur in the same edge that registers tick=1, so out changes together with tick.
REQ-016 BOUNCE: step order is below.
- pos in 0..WIDTH-1.
- dir=1 and pos<WIDTH-1: pos+1.
- dir=1 and pos=WIDTH-1: dir<=0, pos<=WIDTH-2.
- dir=0 and pos>0: pos-1.
- dir=0 and pos=0: dir<=1, pos<=1.
- out = one-hot at bit pos.
REQ-017 WRAP: pos <= (pos+1) mod WIDTH; dir stays 1; out one-hot at pos.
REQ-018 FILL: pos in 0..WIDTH, bounce rules with upper bound WIDTH; out bit i = (i < pos).
REQ-019 mode 11 SHALL decode as BOUNCE.
REQ-020 mode_q SHALL hold the registered raw mode. When mode != mode_q, the next edge SHALL:
- set mode_q <= mode, pos <= 0, dir <= 1, divider <= 0, tick <= 0;
- set out <= decode(0, mode), i.e. BOUNCE/WRAP = bit0 only, FILL = all zero.
REQ-021 A mode change SHALL take priority over a coincident tick; the step is discarded.
REQ-022 A mode change SHALL be accepted even when en=0.
REQ-023 pos arithmetic SHALL be PW bits unsigned and SHALL never leave its legal range for the current mode.

Reset
REQ-024 reset=0 at a rising edge SHALL force all of the following, overriding en, mode and tick:
- out = {WIDTH-1 zeros, 1}
- pos = 0, dir = 1, tick = 0
- divider = 0, mode_q = 00
REQ-025 Reset applied mid-scan SHALL take effect at the very next edge.
REQ-026 If mode != 00 on the first edge after reset releases, REQ-020 applies.

Structure
REQ-027 Package led_scanner_pkg SHALL hold:
- mode encodings MODE_BOUNCE, MODE_WRAP, MODE_FILL, MODE_RSVD;
- the 2-bit mode typedef.
REQ-028 The divider SHALL be a sub-module tick_div (parameter DIV; ports clk, reset, en, clr, tick).
REQ-029 The pattern decode SHALL be a single function of (pos, mode) in the top module.

Verification (WIDTH=4, DIV=1 unless stated)
REQ-030 BOUNCE: reset then en=1 -> out 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; dir falls with the 1000 -> 0100 step.
REQ-031 WRAP: mode=01 from reset -> out 0001 (mode-change edge), then 0010, 0100, 1000, 0001; dir stays 1.
REQ-032 FILL: mode=10 -> out 0000, 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000, 0001; pos reaches 4.
REQ-033 DIV=3: tick every 3rd enabled cycle; en=0 for 5 cycles mid-count -> out, pos and divider frozen; the phase resumes exactly.
REQ-034 Reset mid-scan at pos=2, dir=0 -> next edge out=0001, pos=0, dir=1, tick=0.
REQ-035 Mode change BOUNCE->FILL in the same cycle as a tick -> next edge out=0000, pos=0; the tick is suppressed.

Source files
------------

// File: rtl/led_scanner_pkg.sv
// -----------------------------------------------------------------------------
// led_scanner_pkg
// Purpose : shared definitions for the LED scanner block.
// Contents: the 2-bit raw mode type and its encodings, plus a helper that maps
//           a raw mode onto the pattern actually run (reserved -> BOUNCE).
// -----------------------------------------------------------------------------
package led_scanner_pkg;

  // Raw mode as seen on the mode port and held in mode_q.
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BOUNCE = 2'b00;
  localparam mode_t MODE_WRAP   = 2'b01;
  localparam mode_t MODE_FILL   = 2'b10;
  localparam mode_t MODE_RSVD   = 2'b11;

  // Pattern actually executed for a raw mode; the reserved code behaves as BOUNCE.
  function automatic mode_t eff_mode(input mode_t m);
    mode_t r;
    case (m)
      MODE_WRAP: r = MODE_WRAP;
      MODE_FILL: r = MODE_FILL;
      default:   r = MODE_BOUNCE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_scanner_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
// Purpose : step divider for the LED scanner. Counts 0..DIV-1 on enabled
//           cycles and produces a one-cycle clock-enable on the cycle the count
//           wraps. No clock is derived; everything runs on clk.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-low reset (count -> 0)
//           en    - count advances only while high, holds otherwise
//           clr   - synchronous clear (count -> 0), suppresses tick
//           tick  - combinational enable: high when this edge ends a period
// -----------------------------------------------------------------------------
module tick_div #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // DIV=1 still needs a one-bit counter; it simply never leaves zero.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic          last_s;

  assign last_s = (cnt_q == CNT_LAST);

  // The enable is combinational so the top can step on the same edge that
  // registers its tick output.
  assign tick = reset & en & ~clr & last_s;

  // Period counter: reset/clear to zero, advance on enable, wrap at DIV-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= CNT_ZERO;
    end else if (clr) begin
      cnt_q <= CNT_ZERO;
    end else if (en) begin
      if (last_s) begin
        cnt_q <= CNT_ZERO;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// -----------------------------------------------------------------------------
// led_scanner
// Purpose : drives a row of WIDTH LEDs with a scanning pattern. The pattern
//           advances one step every DIV enabled clock cycles.
//           BOUNCE : single lit LED running up and back down.
//           WRAP   : single lit LED running up, wrapping MSB -> LSB.
//           FILL   : bar graph growing to all-on then shrinking to all-off.
// Ports   : clk   - rising-edge clock (only clock)
//           reset - synchronous, active-low reset
//           en    - high: divider runs and pattern advances; low: all hold
//           mode  - 00 BOUNCE, 01 WRAP, 10 FILL, 11 treated as BOUNCE
//           out   - registered LED drive
//           pos   - registered position (one-hot modes) or level (FILL)
//           dir   - registered direction, 1 = toward MSB
//           tick  - registered one-cycle strobe, high on each step
// -----------------------------------------------------------------------------
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int DIV   = 500000,
  localparam int PW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             tick
);

  localparam logic [PW-1:0] POS_ZERO   = '0;
  localparam logic [PW-1:0] POS_ONE    = PW'(1);
  // Highest legal position for the one-hot patterns and for FILL.
  localparam logic [PW-1:0] TOP_ONEHOT = PW'(WIDTH - 1);
  localparam logic [PW-1:0] TOP_FILL   = PW'(WIDTH);
  localparam logic [WIDTH-1:0] OUT_RESET = {{(WIDTH-1){1'b0}}, 1'b1};

  // LED image for a given position under a given raw mode.
  function automatic logic [WIDTH-1:0] decode(input logic [PW-1:0] p, input mode_t m);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eff_mode(m) == MODE_FILL) begin
        d[i] = (PW'(i) < p);
      end else begin
        d[i] = (PW'(i) == p);
      end
    end
    return d;
  endfunction

  mode_t            mode_q;
  logic [PW-1:0]    pos_q;
  logic             dir_q;
  logic [WIDTH-1:0] out_q;
  logic             tick_q;

  logic             mode_chg_s;
  logic             step_s;
  mode_t            pat_s;
  logic [PW-1:0]    top_s;
  logic [PW-1:0]    step_pos_d;
  logic             step_dir_d;

  // A new raw mode restarts the pattern and the divider phase.
  assign mode_chg_s = (mode != mode_q);
  assign pat_s      = eff_mode(mode_q);
  assign top_s      = (pat_s == MODE_FILL) ? TOP_FILL : TOP_ONEHOT;

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (mode_chg_s),
    .tick  (step_s)
  );

  // Next position/direction if a step were taken now under the held mode.
  always_comb begin
    step_pos_d = pos_q;
    step_dir_d = dir_q;
    case (pat_s)
      MODE_WRAP: begin
        step_dir_d = 1'b1;
        if (pos_q >= TOP_ONEHOT) begin
          step_pos_d = POS_ZERO;
        end else begin
          step_pos_d = pos_q + POS_ONE;
        end
      end
      default: begin
        // BOUNCE and FILL share the turn-around rules; only the top differs.
        if (dir_q) begin
          if (pos_q < top_s) begin
            step_pos_d = pos_q + POS_ONE;
          end else begin
            step_dir_d = 1'b0;
            step_pos_d = top_s - POS_ONE;
          end
        end else begin
          if (pos_q > POS_ZERO) begin
            step_pos_d = pos_q - POS_ONE;
          end else begin
            step_dir_d = 1'b1;
            step_pos_d = POS_ONE;
          end
        end
      end
    endcase
  end

  // Pattern state: reset beats mode change, mode change beats a step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= MODE_BOUNCE;
      pos_q  <= POS_ZERO;
      dir_q  <= 1'b1;
      out_q  <= OUT_RESET;
      tick_q <= 1'b0;
    end else if (mode_chg_s) begin
      mode_q <= mode;
      pos_q  <= POS_ZERO;
      dir_q  <= 1'b1;
      out_q  <= decode(POS_ZERO, mode);
      tick_q <= 1'b0;
    end else if (step_s) begin
      mode_q <= mode_q;
      pos_q  <= step_pos_d;
      dir_q  <= step_dir_d;
      out_q  <= decode(step_pos_d, mode_q);
      tick_q <= 1'b1;
    end else begin
      mode_q <= mode_q;
      pos_q  <= pos_q;
      dir_q  <= dir_q;
      out_q  <= out_q;
      tick_q <= 1'b0;
    end
  end

  assign out  = out_q;
  assign pos  = pos_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_scanner
// Two scanners, WIDTH=4: unit 0 with DIV=1, unit 1 with DIV=3. A step-index
// model predicts every output each cycle; directed literal checks pin the
// sequences for BOUNCE, WRAP, FILL, reset, mode change and divider pausing.
// -----------------------------------------------------------------------------
module tb_led_scanner;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_v  [2];
  logic       en_v   [2];
  logic [1:0] mode_v [2];
  logic [3:0] out_v  [2];
  logic [2:0] pos_v  [2];
  logic       dir_v  [2];
  logic       tick_v [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_scanner #(.WIDTH(W), .DIV(1)) u_a (
    .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .mode(mode_v[0]),
    .out(out_v[0]), .pos(pos_v[0]), .dir(dir_v[0]), .tick(tick_v[0]));

  led_scanner #(.WIDTH(W), .DIV(3)) u_b (
    .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .mode(mode_v[1]),
    .out(out_v[1]), .pos(pos_v[1]), .dir(dir_v[1]), .tick(tick_v[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: step count k since last restart ----------------
  int         divs    [2] = '{1, 3};
  int         m_k     [2];
  int         m_ph    [2];
  logic [1:0] m_mode  [2];
  logic       m_tick  [2];
  bit         m_valid [2] = '{1'b0, 1'b0};

  // 0 bounce, 1 wrap, 2 fill
  function automatic int kind(input logic [1:0] m);
    if (m == 2'b01) return 1;
    if (m == 2'b10) return 2;
    return 0;
  endfunction

  function automatic int m_pos(input logic [1:0] m, input int k);
    int top, per, r;
    if (kind(m) == 1) return k % W;
    top = (kind(m) == 2) ? W : W - 1;
    per = 2 * top;
    r   = k % per;
    return (r <= top) ? r : per - r;
  endfunction

  function automatic int m_dir(input logic [1:0] m, input int k);
    int top, r;
    if (kind(m) == 1) return 1;
    top = (kind(m) == 2) ? W : W - 1;
    r   = k % (2 * top);
    return ((k == 0) || (r >= 1 && r <= top)) ? 1 : 0;
  endfunction

  function automatic int m_out(input logic [1:0] m, input int k);
    int p;
    p = m_pos(m, k);
    return (kind(m) == 2) ? ((1 << p) - 1) : (1 << p);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_v[u]) begin
        m_k[u] <= 0; m_ph[u] <= 0; m_mode[u] <= 2'b00; m_tick[u] <= 1'b0; m_valid[u] <= 1'b1;
      end else if (mode_v[u] != m_mode[u]) begin
        m_k[u] <= 0; m_ph[u] <= 0; m_mode[u] <= mode_v[u]; m_tick[u] <= 1'b0;
      end else if (en_v[u]) begin
        if (m_ph[u] + 1 == divs[u]) begin
          m_ph[u] <= 0; m_k[u] <= m_k[u] + 1; m_tick[u] <= 1'b1;
        end else begin
          m_ph[u] <= m_ph[u] + 1; m_tick[u] <= 1'b0;
        end
      end else begin
        m_tick[u] <= 1'b0;
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (m_valid[u]) begin
        chk($sformatf("model_out%0d", u),  32'(out_v[u]),  32'(m_out(m_mode[u], m_k[u])));
        chk($sformatf("model_pos%0d", u),  32'(pos_v[u]),  32'(m_pos(m_mode[u], m_k[u])));
        chk($sformatf("model_dir%0d", u),  32'(dir_v[u]),  32'(m_dir(m_mode[u], m_k[u])));
        chk($sformatf("model_tick%0d", u), 32'(tick_v[u]), 32'(m_tick[u]));
      end
    end
  end

  // ---------------- directed literal expectations ----------------
  logic [3:0] seq_bounce [7]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic       dir_bounce [7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] seq_wrap   [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       tick_wrap  [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] seq_fill   [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                  4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0001};

  initial begin
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    en_v[0]  = 1'b0; en_v[1]  = 1'b0;
    mode_v[0] = 2'b00; mode_v[1] = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_out",  32'(out_v[0]),  32'h1);
    chk("reset_pos",  32'(pos_v[0]),  32'h0);
    chk("reset_dir",  32'(dir_v[0]),  32'h1);
    chk("reset_tick", 32'(tick_v[0]), 32'h0);

    // BOUNCE from reset
    rst_v[0] = 1'b1; en_v[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bounce_out", 32'(out_v[0]), 32'(seq_bounce[i]));
      chk("bounce_dir", 32'(dir_v[0]), 32'(dir_bounce[i]));
    end
    repeat (3) @(negedge clk);
    chk("mid_pos", 32'(pos_v[0]), 32'h2);
    chk("mid_dir", 32'(dir_v[0]), 32'h0);
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_out",  32'(out_v[0]),  32'h1);
    chk("midrst_pos",  32'(pos_v[0]),  32'h0);
    chk("midrst_dir",  32'(dir_v[0]),  32'h1);
    chk("midrst_tick", 32'(tick_v[0]), 32'h0);

    // WRAP selected while in reset: first edge after release is a mode change
    mode_v[0] = 2'b01; rst_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wrap_out",  32'(out_v[0]),  32'(seq_wrap[i]));
      chk("wrap_tick", 32'(tick_v[0]), 32'(tick_wrap[i]));
      chk("wrap_dir",  32'(dir_v[0]),  32'h1);
    end

    // FILL
    mode_v[0] = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fill_out", 32'(out_v[0]), 32'(seq_fill[i]));
      if (i == 4) chk("fill_top", 32'(pos_v[0]), 32'h4);
    end

    // BOUNCE -> FILL on a tick cycle: the step is dropped
    mode_v[0] = 2'b00;
    repeat (3) @(negedge clk);
    chk("pre_chg_pos", 32'(pos_v[0]), 32'h2);
    mode_v[0] = 2'b10;
    @(negedge clk);
    chk("chg_out",  32'(out_v[0]),  32'h0);
    chk("chg_pos",  32'(pos_v[0]),  32'h0);
    chk("chg_tick", 32'(tick_v[0]), 32'h0);

    // mode change accepted with en=0, then everything holds
    repeat (2) @(negedge clk);
    en_v[0] = 1'b0; mode_v[0] = 2'b01;
    @(negedge clk);
    chk("en0_chg_out",  32'(out_v[0]),  32'h1);
    chk("en0_chg_tick", 32'(tick_v[0]), 32'h0);
    repeat (3) @(negedge clk);
    chk("en0_hold_out", 32'(out_v[0]), 32'h1);

    // reserved mode runs as BOUNCE
    en_v[0] = 1'b1; mode_v[0] = 2'b11;
    repeat (5) @(negedge clk);
    chk("rsvd_pos", 32'(pos_v[0]), 32'h2);
    chk("rsvd_dir", 32'(dir_v[0]), 32'h0);

    // DIV=3 unit: tick every third enabled cycle, pause keeps phase
    rst_v[1] = 1'b1; en_v[1] = 1'b1;
    @(negedge clk); chk("div_t1", 32'(tick_v[1]), 32'h0);
    @(negedge clk); chk("div_t2", 32'(tick_v[1]), 32'h0);
    chk("div_out2", 32'(out_v[1]), 32'h1);
    @(negedge clk); chk("div_t3", 32'(tick_v[1]), 32'h1);
    chk("div_out3", 32'(out_v[1]), 32'h2);
    @(negedge clk); chk("div_t4", 32'(tick_v[1]), 32'h0);
    en_v[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_tick", 32'(tick_v[1]), 32'h0);
      chk("pause_out",  32'(out_v[1]),  32'h2);
      chk("pause_pos",  32'(pos_v[1]),  32'h1);
    end
    en_v[1] = 1'b1;
    @(negedge clk); chk("resume_t1", 32'(tick_v[1]), 32'h0);
    @(negedge clk); chk("resume_t2", 32'(tick_v[1]), 32'h1);
    chk("resume_out", 32'(out_v[1]), 32'h4);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
